// File: rtl/socket_sink_checker_pkg.sv
// Shared FSM state type, default parameters and sizing helper for the
// socket sink checker and its reference counter.
package socket_sink_checker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } sink_state_t;

    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_SOCKET_SIZE = 5;
    localparam int DEF_MAX_VAL     = 256;
    localparam int DEF_CNT_WIDTH   = 32;

    // Width of the read index; it only has to reach size-1.
    function automatic int idx_width(input int size);
        return (size < 2) ? 1 : $clog2(size);
    endfunction

endpackage

// File: rtl/socket_sink_checker_ref_counter.sv
// Golden counter sequence 0..MAX_VAL-1 with wrap; a load overrides the
// advance so the checker can resynchronise after a mismatch.
module ref_counter
    import socket_sink_checker_pkg::*;
#(
    parameter int MAX_VAL    = DEF_MAX_VAL,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_val,
    output logic [DATA_WIDTH-1:0] out
);

    localparam logic [DATA_WIDTH-1:0] LAST_VAL = DATA_WIDTH'(MAX_VAL - 1);

    logic [DATA_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0] cnt_d;

    // Next count: load wins over advance.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (advance) begin
            cnt_d = (cnt_q == LAST_VAL) ? '0 : cnt_q + DATA_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out = cnt_q;

endmodule

// File: rtl/socket_sink_checker.sv
// Frame-draining sink at the tail of a socket chain: pops whole frames and
// checks every word against the wrapping counter sequence, with statistics.
module socket_sink_checker
    import socket_sink_checker_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SOCKET_SIZE = DEF_SOCKET_SIZE,
    parameter int MAX_VAL     = DEF_MAX_VAL,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic                  i_full,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_rd_en,
    output logic                  o_busy,
    output logic                  o_frame_done,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_frame_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt
);

    localparam int                    IDX_W    = idx_width(SOCKET_SIZE);
    localparam int                    DW1      = DATA_WIDTH + 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(SOCKET_SIZE - 1);
    localparam logic [DW1-1:0]        MAX_W    = DW1'(MAX_VAL);
    localparam logic [DATA_WIDTH-1:0] LAST_VAL = DATA_WIDTH'(MAX_VAL - 1);

    sink_state_t           state_q, state_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic                  rd_vld_q;
    logic                  err_q;
    logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
    logic [CNT_WIDTH-1:0]  err_cnt_q, err_cnt_d;
    logic                  rd_req_s;
    logic                  in_range_s;
    logic                  mismatch_s;
    logic [DATA_WIDTH-1:0] resync_val_s;
    logic [DATA_WIDTH-1:0] exp_s;

    // Frame FSM; the first pop is issued from IDLE in the start cycle.
    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        rd_req_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_en && i_full) begin
                    rd_req_s = 1'b1;
                    rd_idx_d = (SOCKET_SIZE > 1) ? IDX_W'(1) : '0;
                    state_d  = (SOCKET_SIZE > 1) ? READ : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
            READ: begin
                rd_req_s = 1'b1;
                if (rd_idx_q == LAST_IDX) begin
                    rd_idx_d = '0;
                    state_d  = WAIT;
                end else begin
                    rd_idx_d = rd_idx_q + IDX_W'(1);
                    state_d  = READ;
                end
            end
            WAIT:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: begin
                state_d  = IDLE;
                rd_idx_d = '0;
            end
        endcase
    end

    // Out-of-range words resync to zero, otherwise to the successor of the word seen.
    assign in_range_s   = {1'b0, i_data} < MAX_W;
    assign mismatch_s   = rd_vld_q && (!in_range_s || (i_data != exp_s));
    assign resync_val_s = (!in_range_s || (i_data == LAST_VAL)) ? '0 : i_data + DATA_WIDTH'(1);

    ref_counter #(
        .MAX_VAL    (MAX_VAL),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ref_counter (
        .clk      (i_clk),
        .rst      (i_rst),
        .advance  (rd_vld_q && !mismatch_s),
        .load     (mismatch_s),
        .load_val (resync_val_s),
        .out      (exp_s)
    );

    // Saturating frame and error statistics.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if ((state_q == DONE) && (frame_cnt_q != '1)) begin
            frame_cnt_d = frame_cnt_q + CNT_WIDTH'(1);
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
        if (mismatch_s && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, pipeline and statistics registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= IDLE;
            rd_idx_q    <= '0;
            rd_vld_q    <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            rd_idx_q    <= rd_idx_d;
            rd_vld_q    <= rd_req_s;
            err_q       <= mismatch_s;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // The pop strobe is combinational, so hold it low while reset is asserted.
    assign o_rd_en      = rd_req_s && i_rst;
    assign o_busy       = (state_q != IDLE);
    assign o_frame_done = (state_q == DONE);
    assign o_err        = err_q;
    assign o_frame_cnt  = frame_cnt_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_socket_sink_checker.sv
// Scoreboarded bench for socket_sink_checker: a default instance (MAX_VAL=256)
// and a small one (MAX_VAL=8, CNT_WIDTH=3) share a modelled socket.
module tb_socket_sink_checker;

    typedef struct packed {
        logic err_a;
        logic err_b;
        logic done;
    } sb_t;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        full;
    logic [15:0] data;

    logic        a_rd, a_busy, a_done, a_err;
    logic [31:0] a_fcnt, a_ecnt;
    logic        b_rd, b_busy, b_done, b_err;
    logic [2:0]  b_fcnt, b_ecnt;

    int   checks = 0;
    int   errors = 0;
    sb_t  sb_q[$];
    int   sock_q[$];
    int   exp_a, exp_b, ec_a, ec_b, fc_a, fc_b;
    int   pops_a, pops_b;
    bit   pend;
    int   pend_word;

    socket_sink_checker dut_a (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_full(full), .i_data(data),
        .o_rd_en(a_rd), .o_busy(a_busy), .o_frame_done(a_done), .o_err(a_err),
        .o_frame_cnt(a_fcnt), .o_err_cnt(a_ecnt)
    );

    socket_sink_checker #(.MAX_VAL(8), .CNT_WIDTH(3)) dut_b (
        .i_clk(clk), .i_rst(rst_n), .i_en(en), .i_full(full), .i_data(data),
        .o_rd_en(b_rd), .o_busy(b_busy), .o_frame_done(b_done), .o_err(b_err),
        .o_frame_cnt(b_fcnt), .o_err_cnt(b_ecnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_word(inout int e, input int w, input int m);
        bit bad;
        bad = (w >= m) || (w != e);
        e = (w >= m) ? 0 : (w + 1) % m;
        return bad;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_a_rd"}, {31'd0, a_rd}, 32'd0);
        chk({tag, "_a_busy"}, {31'd0, a_busy}, 32'd0);
        chk({tag, "_a_done"}, {31'd0, a_done}, 32'd0);
        chk({tag, "_a_err"}, {31'd0, a_err}, 32'd0);
        chk({tag, "_a_fcnt"}, a_fcnt, 32'd0);
        chk({tag, "_a_ecnt"}, a_ecnt, 32'd0);
        chk({tag, "_b_rd"}, {31'd0, b_rd}, 32'd0);
        chk({tag, "_b_fcnt"}, {29'd0, b_fcnt}, 32'd0);
        chk({tag, "_b_ecnt"}, {29'd0, b_ecnt}, 32'd0);
    endtask

    // One clock: observe pops of this cycle, push expectations, advance,
    // present popped data, compare outputs due in the new cycle.
    task automatic step();
        sb_t e;
        int  w;
        e = '0;
        #1;
        if (b_rd) pops_b++;
        if (a_rd) begin
            pops_a++;
            if (sock_q.size() > 0) w = sock_q.pop_front();
            else w = 32'h0000_ffff;
            e.err_a = model_word(exp_a, w, 256);
            e.err_b = model_word(exp_b, w, 8);
            if (e.err_a) ec_a++;
            if (e.err_b && ec_b < 7) ec_b++;
            if (pops_a == 5) begin
                e.done = 1'b1;
                fc_a++;
                if (fc_b < 7) fc_b++;
            end
            pend      = 1'b1;
            pend_word = w;
        end else begin
            pend = 1'b0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (pend) data = pend_word[15:0];
        e = sb_q.pop_front();
        chk("err_a", {31'd0, a_err}, {31'd0, e.err_a});
        chk("err_b", {31'd0, b_err}, {31'd0, e.err_b});
        chk("done_a", {31'd0, a_done}, {31'd0, e.done});
        chk("done_b", {31'd0, b_done}, {31'd0, e.done});
    endtask

    task automatic run_frame(input int w[5], input int drop_at);
        int n;
        sock_q.delete();
        for (int i = 0; i < 5; i++) sock_q.push_back(w[i]);
        pops_a = 0;
        pops_b = 0;
        full   = 1'b1;
        n      = 0;
        while (pops_a < 5 && n < 20) begin
            step();
            n++;
            if (pops_a >= drop_at) full = 1'b0;
        end
        full = 1'b0;
        repeat (3) step();
        chk("pops_a", pops_a, 5);
        chk("pops_b", pops_b, 5);
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, "_fcnt_a"}, a_fcnt, fc_a);
        chk({tag, "_ecnt_a"}, a_ecnt, ec_a);
        chk({tag, "_fcnt_b"}, {29'd0, b_fcnt}, fc_b);
        chk({tag, "_ecnt_b"}, {29'd0, b_ecnt}, ec_b);
    endtask

    task automatic model_reset();
        exp_a = 0; exp_b = 0; ec_a = 0; ec_b = 0; fc_a = 0; fc_b = 0;
        pend = 1'b0;
        sb_q.delete();
        sb_q.push_back('0);
        sock_q.delete();
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        full  = 1'b0;
        data  = 16'd0;
        model_reset();
        #3;
        chk_all_zero("por");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;

        // Nominal counting frames.
        run_frame('{0, 1, 2, 3, 4}, 5);
        run_frame('{5, 6, 7, 8, 9}, 5);
        chk_counts("nominal");
        chk("nominal_fcnt_const", a_fcnt, 32'd2);
        chk("nominal_ecnt_const", a_ecnt, 32'd0);

        // Reset in the middle of a frame.
        sock_q.delete();
        for (int i = 0; i < 5; i++) sock_q.push_back(i + 10);
        pops_a = 0;
        full   = 1'b1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        full = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // Single error and resync, then clean follow-on frame.
        run_frame('{0, 1, 9, 10, 11}, 5);
        chk("resync_ecnt_const", a_ecnt, 32'd1);
        run_frame('{12, 13, 14, 15, 16}, 5);
        chk_counts("resync");
        chk("sat_ecnt_b_const", {29'd0, b_ecnt}, 32'd7);

        // Disabled with a full socket: nothing may be popped.
        en     = 1'b0;
        full   = 1'b1;
        pops_a = 0;
        pops_b = 0;
        repeat (4) step();
        chk("noen_pops_a", pops_a, 0);
        chk("noen_pops_b", pops_b, 0);
        en = 1'b1;
        run_frame('{17, 18, 19, 20, 21}, 2);

        // Wrap through MAX_VAL on the small instance.
        run_frame('{0, 1, 2, 3, 4}, 5);
        run_frame('{5, 6, 7, 0, 1}, 5);
        chk_counts("final");
        chk("final_fcnt_a_const", a_fcnt, 32'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
